sync_supervisor: RTL

SYNC_SUPERVISOR -- requirements
Module: sync_supervisor

---
 rtl/sync_supervisor_pkg.sv | 26 ++
 rtl/sync_supervisor_satcounter.sv | 23 ++
 rtl/sync_supervisor.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sync_supervisor_pkg.sv
// Shared definitions for the PCS sync supervisor: state encodings,
// logic-level constants and the event-counter saturation limit.
package sync_supervisor_pkg;

    // One-hot encodings; each bit is one state so the output decode stays a single OR.
    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_RESET   = 6'b000010,
        ST_ACQUIRE = 6'b000100,
        ST_QUALIFY = 6'b001000,
        ST_LOCKED  = 6'b010000,
        ST_FAULT   = 6'b100000
    } state_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic OK    = 1'b1;
    localparam logic FAIL  = 1'b0;

    localparam logic [7:0] SAT_LIMIT = 8'd255;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_supervisor_satcounter.sv
// Eight-bit event counter that sticks at SAT_LIMIT and clears only on reset.
module SatCounter8
    import sync_supervisor_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_inc,
    output logic [7:0] o_count
);

    logic [7:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != SAT_LIMIT)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sync_supervisor.sv
// Supervises a code-group synchronization block: resets it, watches acquisition,
// qualifies lock stability and gives up after repeated acquisition timeouts.
module sync_supervisor
    import sync_supervisor_pkg::*;
#(
    parameter int RST_CYCLES  = 4,
    parameter int ACQ_TIMEOUT = 64,
    parameter int STABLE_CGS  = 16,
    parameter int MAX_RETRIES = 7
) (
    input  logic       Clk,
    input  logic       mr_main_reset_n,
    input  logic       enable,
    input  logic       code_sync_status,
    input  logic       PUDI_indicate_in,
    output logic       sync_reset,
    output logic       PUDI_indicate_out,
    output logic       sync_ok,
    output logic       fault,
    output logic [7:0] resync_count,
    output logic [7:0] loss_count
);

    localparam int CW = $clog2(maxOf(ACQ_TIMEOUT, STABLE_CGS)) + 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int TW = $clog2(MAX_RETRIES + 2);

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_cgCount;
    logic [CW-1:0]   w_cgNext;
    logic [CW-1:0]   w_cgInc;
    logic [RW-1:0]   r_rstCount;
    logic [RW-1:0]   w_rstNext;
    logic [TW-1:0]   r_retries;
    logic [TW-1:0]   w_retriesNext;
    logic [TW-1:0]   w_retriesInc;
    logic            w_resyncInc;
    logic            w_lossInc;
    logic            w_active;

    assign w_cgInc      = r_cgCount + CW'(1);
    assign w_retriesInc = r_retries + TW'(1);

    always_ff @(posedge Clk) begin
        if (!mr_main_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_cgNext      = r_cgCount;
        w_rstNext     = r_rstCount;
        w_retriesNext = r_retries;
        w_resyncInc   = FALSE;
        w_lossInc     = FALSE;
        if (!enable) begin
            w_nextState = ST_IDLE;
            w_cgNext    = '0;
            w_rstNext   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_nextState   = ST_RESET;
                    w_rstNext     = '0;
                    w_retriesNext = '0;
                end
                ST_RESET: begin
                    if (r_rstCount == RW'(RST_CYCLES - 1)) begin
                        w_nextState = ST_ACQUIRE;
                        w_cgNext    = '0;
                    end else begin
                        w_rstNext = r_rstCount + RW'(1);
                    end
                end
                ST_ACQUIRE: begin
                    // Sync arriving on the timeout strobe still counts as acquired.
                    if (code_sync_status == OK) begin
                        w_nextState = ST_QUALIFY;
                        w_cgNext    = '0;
                    end else if (PUDI_indicate_in) begin
                        if (w_cgInc == CW'(ACQ_TIMEOUT)) begin
                            w_resyncInc   = TRUE;
                            w_retriesNext = w_retriesInc;
                            w_cgNext      = '0;
                            w_rstNext     = '0;
                            w_nextState   = (w_retriesInc > TW'(MAX_RETRIES)) ? ST_FAULT : ST_RESET;
                        end else begin
                            w_cgNext = w_cgInc;
                        end
                    end
                end
                ST_QUALIFY: begin
                    if (code_sync_status == FAIL) begin
                        w_nextState = ST_ACQUIRE;
                        w_cgNext    = '0;
                    end else if (PUDI_indicate_in) begin
                        if (w_cgInc == CW'(STABLE_CGS)) begin
                            w_nextState   = ST_LOCKED;
                            w_cgNext      = '0;
                            w_retriesNext = '0;
                        end else begin
                            w_cgNext = w_cgInc;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (code_sync_status == FAIL) begin
                        w_lossInc   = TRUE;
                        w_nextState = ST_ACQUIRE;
                        w_cgNext    = '0;
                    end
                end
                ST_FAULT: begin
                    w_nextState = ST_FAULT;
                end
                default: begin
                    w_nextState = ST_IDLE;
                    w_cgNext    = '0;
                    w_rstNext   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!mr_main_reset_n) begin
            r_cgCount  <= '0;
            r_rstCount <= '0;
            r_retries  <= '0;
        end else begin
            r_cgCount  <= w_cgNext;
            r_rstCount <= w_rstNext;
            r_retries  <= w_retriesNext;
        end
    end

    assign w_active = (r_state == ST_ACQUIRE) || (r_state == ST_QUALIFY) || (r_state == ST_LOCKED);

    assign sync_reset        = (r_state == ST_IDLE) || (r_state == ST_RESET) || (r_state == ST_FAULT);
    assign PUDI_indicate_out = PUDI_indicate_in && w_active;
    assign sync_ok           = (r_state == ST_LOCKED);
    assign fault             = (r_state == ST_FAULT);

    SatCounter8 u_resyncCounter (
        .i_clk   (Clk),
        .i_rst_n (mr_main_reset_n),
        .i_inc   (w_resyncInc),
        .o_count (resync_count)
    );

    SatCounter8 u_lossCounter (
        .i_clk   (Clk),
        .i_rst_n (mr_main_reset_n),
        .i_inc   (w_lossInc),
        .o_count (loss_count)
    );

endmodule
